// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scancode constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_S = 8'h1B;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock conditioning: synchroniser, glitch filter and falling-edge
// detector. Everything resets high to match the idle bus.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic din,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   prev_q, prev_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Filter: level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    prev_d = filt_q;
    if (s != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = s;
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  // Conditioning registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, checks start/parity/
// stop, and presents good bytes on ps2_out with a held strobe.
// Optional: define PS2_BREAK_FILTER_EN to swallow F0 and the byte after it.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int STROBE_CYC  = 16
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] ps2_out,
  output logic       ps2_key_pressed,
  output logic       frame_err
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(STROBE_CYC + 1);

  logic                   clk_fall, dat_s;
  logic [SYNC_STAGES-1:0] dsync_q, dsync_d;

  ps2_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [7:0]    out_q, out_d;
  logic          key_q, key_d;
  logic [SW-1:0] stb_q, stb_d;
  logic          ferr_q, ferr_d;
`ifdef PS2_BREAK_FILTER_EN
  logic          bp_q, bp_d;
`endif

  logic timeout_hit, good, bad, present;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .din      (ps2_clk_in),
    .fall     (clk_fall)
  );

  // Data line is only sampled mid-bit, so it needs synchronising, not filtering.
  assign dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_dat_in};
  assign dat_s   = dsync_q[SYNC_STAGES-1];

  // A fall on the terminal idle cycle still counts as a bit.
  assign timeout_hit = (state_q != IDLE) && !clk_fall &&
                       (idle_q == IW'(TIMEOUT_CYC - 1));
  assign good = (state_q == STOP) && clk_fall && dat_s && (^{shreg_q, par_q});
  assign bad  = ((state_q == STOP) && clk_fall && !good) ||
                ((state_q == IDLE) && clk_fall && dat_s) ||
                timeout_hit;

  // State and datapath registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      dsync_q   <= '1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      idle_q    <= '0;
    end else begin
      dsync_q   <= dsync_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      idle_q    <= idle_d;
    end
  end

  // Next state: frame sequencing on clock falls, with idle timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    idle_d    = '0;
    case (state_q)
      IDLE: if (clk_fall && !dat_s) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (clk_fall) begin
        shreg_d = {dat_s, shreg_q[7:1]};
        if (bit_cnt_q == 3'd7) begin
          state_d   = PARITY;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: if (clk_fall) begin
        par_d   = dat_s;
        state_d = STOP;
      end
      STOP: if (clk_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d != IDLE && !clk_fall)
      idle_d = idle_q + IW'(1);
    if (timeout_hit) state_d = IDLE;
  end

  // Outputs: present good bytes, run the strobe counter, flag errors.
  always_comb begin
    out_d   = out_q;
    key_d   = key_q;
    stb_d   = stb_q;
    ferr_d  = bad;
    present = good;
`ifdef PS2_BREAK_FILTER_EN
    bp_d = bp_q;
    if (good) begin
      if (bp_q) begin
        bp_d    = 1'b0;
        present = 1'b0;
      end else if (shreg_q == PS2_BREAK) begin
        bp_d    = 1'b1;
        present = 1'b0;
      end
    end
`endif
    if (present) begin
      out_d = shreg_q;
      key_d = 1'b1;
      stb_d = SW'(STROBE_CYC);
    end else if (stb_q != '0) begin
      stb_d = stb_q - SW'(1);
      key_d = (stb_q != SW'(1));
    end
  end

  // Output registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      out_q  <= 8'h00;
      key_q  <= 1'b0;
      stb_q  <= '0;
      ferr_q <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      bp_q   <= 1'b0;
`endif
    end else begin
      out_q  <= out_d;
      key_q  <= key_d;
      stb_q  <= stb_d;
      ferr_q <= ferr_d;
`ifdef PS2_BREAK_FILTER_EN
      bp_q   <= bp_d;
`endif
    end
  end

  assign ps2_out         = out_q;
  assign ps2_key_pressed = key_q;
  assign frame_err       = ferr_q;

endmodule
